// File: rtl/bch_bench_serdes_pkg.sv
// Shared types and elaboration helpers for the BCH benchmark serial load/unload harness.
package bch_bench_serdes_pkg;

   typedef enum logic {
      RX_IDLE = 1'b0,
      RX_DATA = 1'b1
   } rx_state_t;

   typedef enum logic [1:0] {
      TX_IDLE = 2'd0,
      TX_MARK = 2'd1,
      TX_DATA = 2'd2
   } tx_state_t;

   // Ceiling divide; a zero divisor is caught separately by the parameter check.
   function automatic int cdiv(input int a, input int b);
      return (b < 1) ? a : (a + b - 1) / b;
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/bch_bench_sync_pipe.sv
// N-deep, W-wide flop chain used both as input synchroniser and output pipeline.
module bch_bench_sync_pipe #(
   parameter int W = 1,
   parameter int N = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] stage [N];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N; i++) stage[i] <= '0;
      end else begin
         stage[0] <= d;
         for (int i = 1; i < N; i++) stage[i] <= stage[i-1];
      end
   end

   assign q = stage[N-1];

endmodule

// File: rtl/bch_bench_serdes.sv
// Framed multi-lane serial-to-parallel loader and parallel-to-serial unloader
// for pin-limited benchmarking of BCH cores; RX and TX paths are independent.
module bch_bench_serdes
   import bch_bench_serdes_pkg::*;
#(
   parameter int IN_W        = 32,
   parameter int OUT_W       = 32,
   parameter int LANES       = 1,
   parameter int SYNC_STAGES = 2,
   parameter int OUT_STAGES  = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [LANES-1:0] ser_in,
   output logic [IN_W-1:0]  par_out,
   output logic             par_valid,
   input  logic [OUT_W-1:0] cap_data,
   input  logic             cap_valid,
   output logic             cap_ready,
   output logic [LANES-1:0] ser_out,
   output logic             overrun
);

   localparam int IN_BEATS  = cdiv(IN_W, LANES);
   localparam int OUT_BEATS = cdiv(OUT_W, LANES);
   localparam int OUT_SR_W  = OUT_BEATS * LANES;
   localparam int CNT_W     = $clog2(max2(IN_BEATS, OUT_BEATS) + 1);

   if (IN_W < 1 || OUT_W < 1 || LANES < 1 || SYNC_STAGES < 1 || OUT_STAGES < 1) begin : g_param_err
      $error("bch_bench_serdes: IN_W, OUT_W, LANES, SYNC_STAGES and OUT_STAGES must all be >= 1");
   end

   logic [LANES-1:0] s;

   bch_bench_sync_pipe #(.W(LANES), .N(SYNC_STAGES)) u_in_sync (
      .clk   (clk),
      .reset (reset),
      .d     (ser_in),
      .q     (s)
   );

   // Receive path. Only the low IN_W bits are kept, so leading pad bits fall off the top.
   rx_state_t        rx_state, rx_state_nx;
   logic [CNT_W-1:0] rx_cnt;
   logic [IN_W-1:0]  rx_sr;
   logic [IN_W-1:0]  rx_shift;
   logic             rx_last;

   assign rx_shift = IN_W'({rx_sr, s});
   assign rx_last  = (rx_state == RX_DATA) && (rx_cnt == CNT_W'(IN_BEATS - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) rx_state <= RX_IDLE;
      else       rx_state <= rx_state_nx;
   end

   always_comb begin
      rx_state_nx = rx_state;
      case (rx_state)
         RX_IDLE: if (s[0])   rx_state_nx = RX_DATA;
         RX_DATA: if (rx_last) rx_state_nx = RX_IDLE;
         default:             rx_state_nx = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_cnt    <= '0;
         rx_sr     <= '0;
         par_out   <= '0;
         par_valid <= 1'b0;
      end else begin
         par_valid <= 1'b0;
         if (rx_state == RX_IDLE) begin
            rx_cnt <= '0;
         end else begin
            rx_sr  <= rx_shift;
            rx_cnt <= rx_cnt + CNT_W'(1);
            if (rx_last) begin
               par_out   <= rx_shift;
               par_valid <= 1'b1;
            end
         end
      end
   end

   // Transmit path: a one-cycle all-ones marker, then OUT_BEATS beats MSB first.
   tx_state_t             tx_state, tx_state_nx;
   logic [CNT_W-1:0]      tx_cnt;
   logic [OUT_SR_W-1:0]   tx_sr;
   logic [OUT_SR_W-1:0]   tx_shift;
   logic [LANES-1:0]      tx_line;
   logic                  tx_last;

   assign tx_shift = OUT_SR_W'({tx_sr, {LANES{1'b0}}});
   assign tx_last  = (tx_cnt == CNT_W'(OUT_BEATS - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) tx_state <= TX_IDLE;
      else       tx_state <= tx_state_nx;
   end

   always_comb begin
      tx_state_nx = tx_state;
      cap_ready   = 1'b0;
      tx_line     = '0;
      case (tx_state)
         TX_IDLE: begin
            cap_ready = 1'b1;
            if (cap_valid) tx_state_nx = TX_MARK;
         end
         TX_MARK: begin
            tx_line     = '1;
            tx_state_nx = TX_DATA;
         end
         TX_DATA: begin
            tx_line = tx_sr[OUT_SR_W-1 -: LANES];
            if (tx_last) tx_state_nx = TX_IDLE;
         end
         default: tx_state_nx = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_sr   <= '0;
         tx_cnt  <= '0;
         overrun <= 1'b0;
      end else begin
         if (cap_valid && !cap_ready) overrun <= 1'b1;
         case (tx_state)
            TX_IDLE: begin
               tx_cnt <= '0;
               if (cap_valid) tx_sr <= OUT_SR_W'(cap_data) << (OUT_SR_W - OUT_W);
            end
            TX_MARK: tx_cnt <= '0;
            TX_DATA: begin
               tx_sr  <= tx_shift;
               tx_cnt <= tx_cnt + CNT_W'(1);
            end
            default: tx_cnt <= '0;
         endcase
      end
   end

   bch_bench_sync_pipe #(.W(LANES), .N(OUT_STAGES)) u_out_pipe (
      .clk   (clk),
      .reset (reset),
      .d     (tx_line),
      .q     (ser_out)
   );

endmodule

// File: tb/tb_bch_bench_serdes.sv
// Bench for bch_bench_serdes: a 1-lane 8-bit instance and a 4-lane 10-bit instance
// checked against frame-level expectations computed from the serial format.
module tb_bch_bench_serdes;

   logic       clk = 1'b0;
   logic       reset;
   int         total = 0;
   int         bad   = 0;

   logic       ser_in_a, par_valid_a, cap_valid_a, cap_ready_a, ser_out_a, overrun_a;
   logic [7:0] par_out_a, cap_data_a;
   logic [3:0] ser_in_b, ser_out_b;
   logic [9:0] par_out_b, cap_data_b;
   logic       par_valid_b, cap_valid_b, cap_ready_b, overrun_b;

   logic [7:0] q_a [$];
   logic [9:0] q_b [$];

   always #5 clk = ~clk;

   bch_bench_serdes #(.IN_W(8), .OUT_W(8), .LANES(1), .SYNC_STAGES(2), .OUT_STAGES(2)) dut_a (
      .clk(clk), .reset(reset), .ser_in(ser_in_a), .par_out(par_out_a), .par_valid(par_valid_a),
      .cap_data(cap_data_a), .cap_valid(cap_valid_a), .cap_ready(cap_ready_a),
      .ser_out(ser_out_a), .overrun(overrun_a)
   );

   bch_bench_serdes #(.IN_W(10), .OUT_W(10), .LANES(4), .SYNC_STAGES(2), .OUT_STAGES(2)) dut_b (
      .clk(clk), .reset(reset), .ser_in(ser_in_b), .par_out(par_out_b), .par_valid(par_valid_b),
      .cap_data(cap_data_b), .cap_valid(cap_valid_b), .cap_ready(cap_ready_b),
      .ser_out(ser_out_b), .overrun(overrun_b)
   );

   // Every par_valid pulse is logged so pulse counts and back-to-back words can be checked.
   always @(negedge clk) begin
      if (par_valid_a) q_a.push_back(par_out_a);
      if (par_valid_b) q_b.push_back(par_out_b);
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic int beats_of(input int inst);
      return (inst == 0) ? 8 : 3;
   endfunction

   function automatic int lanes_of(input int inst);
      return (inst == 0) ? 1 : 4;
   endfunction

   // Expected TX line value m cycles after the marker cycle (m=0 is the marker).
   function automatic logic [3:0] tx_expect(input int inst, input int data, input int m);
      int beats   = beats_of(inst);
      int lanes   = lanes_of(inst);
      int mask    = (1 << lanes) - 1;
      int aligned = (inst == 0) ? data : (data << 2);
      if (m == 0) return 4'(mask);
      if (m >= 1 && m <= beats) return 4'((aligned >> (lanes * (beats - m))) & mask);
      return 4'h0;
   endfunction

   function automatic logic rd_par_valid(input int inst);
      return (inst == 0) ? par_valid_a : par_valid_b;
   endfunction

   function automatic logic [9:0] rd_par_out(input int inst);
      return (inst == 0) ? {2'b00, par_out_a} : par_out_b;
   endfunction

   function automatic logic [3:0] rd_ser_out(input int inst);
      return (inst == 0) ? {3'b000, ser_out_a} : ser_out_b;
   endfunction

   function automatic logic rd_cap_ready(input int inst);
      return (inst == 0) ? cap_ready_a : cap_ready_b;
   endfunction

   function automatic logic rd_overrun(input int inst);
      return (inst == 0) ? overrun_a : overrun_b;
   endfunction

   task automatic drive_lanes(input int inst, input logic [3:0] v);
      if (inst == 0) ser_in_a = v[0];
      else           ser_in_b = v;
   endtask

   task automatic drive_cap(input int inst, input logic valid, input logic [9:0] data);
      if (inst == 0) begin
         cap_valid_a = valid;
         cap_data_a  = data[7:0];
      end else begin
         cap_valid_b = valid;
         cap_data_b  = data;
      end
   endtask

   // Marker beat then every beat of the padded frame, one per cycle; the last beat stays driven.
   task automatic rx_drive(input int inst, input logic [11:0] padded);
      int beats = beats_of(inst);
      int lanes = lanes_of(inst);
      int mask  = (1 << lanes) - 1;
      int pv    = int'(padded);
      @(posedge clk); #1;
      drive_lanes(inst, (inst == 0) ? 4'h1 : {3'($urandom), 1'b1});
      for (int j = 0; j < beats; j++) begin
         @(posedge clk); #1;
         drive_lanes(inst, 4'((pv >> (lanes * (beats - 1 - j))) & mask));
      end
   endtask

   task automatic rx_wait(input int inst, output int lat);
      lat = 0;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         if (k == 1) drive_lanes(inst, 4'h0);
         if (rd_par_valid(inst)) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic tx_accept(input int inst, input logic [9:0] data);
      @(posedge clk); #1;
      drive_cap(inst, 1'b1, data);
      @(posedge clk); #1;
      drive_cap(inst, 1'b0, 10'h0);
      total++;
      if (rd_cap_ready(inst) !== 1'b0) begin
         bad++;
         $display("[TB] FAIL tx_accept inst%0d: cap_ready=%b expected 0", inst, rd_cap_ready(inst));
      end
   endtask

   // Observes the stream after acceptance; inject>0 pulses cap_valid with all ones mid-stream.
   task automatic tx_observe(input int inst, input logic [9:0] data, input int inject);
      int beats = beats_of(inst);
      for (int k = 1; k <= beats + 4; k++) begin
         @(posedge clk); #1;
         if (k == inject) drive_cap(inst, 1'b1, 10'h3FF);
         else             drive_cap(inst, 1'b0, 10'h0);
         total++;
         if (rd_ser_out(inst) !== tx_expect(inst, int'(data), k - 2)) begin
            bad++;
            $display("[TB] FAIL tx_stream inst%0d k=%0d: ser_out=%h expected %h", inst, k, rd_ser_out(inst), tx_expect(inst, int'(data), k - 2));
         end
         total++;
         if (rd_cap_ready(inst) !== (k > beats)) begin
            bad++;
            $display("[TB] FAIL tx_ready inst%0d k=%0d: cap_ready=%b expected %b", inst, k, rd_cap_ready(inst), (k > beats));
         end
      end
   endtask

   task automatic check_rx(input string name, input int inst, input int lat, input logic [9:0] exp);
      total++;
      if (lat !== 3) begin
         bad++;
         $display("[TB] FAIL %s latency inst%0d: got %0d expected 3", name, inst, lat);
      end
      total++;
      if (rd_par_out(inst) !== exp) begin
         bad++;
         $display("[TB] FAIL %s par_out inst%0d: got %h expected %h", name, inst, rd_par_out(inst), exp);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      ser_in_a = 1'b0; ser_in_b = 4'h0;
      drive_cap(0, 1'b0, 10'h0);
      drive_cap(1, 1'b0, 10'h0);
      repeat (3) @(posedge clk);
      #1;
      for (int inst = 0; inst < 2; inst++) begin
         total++;
         if (rd_par_out(inst) !== 10'h0 || rd_par_valid(inst) !== 1'b0 || rd_ser_out(inst) !== 4'h0 ||
             rd_cap_ready(inst) !== 1'b1 || rd_overrun(inst) !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_state inst%0d: par_out=%h pv=%b ser_out=%h ready=%b ovr=%b expected 0/0/0/1/0",
                     inst, rd_par_out(inst), rd_par_valid(inst), rd_ser_out(inst), rd_cap_ready(inst), rd_overrun(inst));
         end
      end
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_rx_directed();
      int lat;
      q_a.delete();
      rx_drive(0, 12'h0A5);
      rx_wait(0, lat);
      check_rx("rx_a5", 0, lat, 10'h0A5);
      @(posedge clk); #1;
      total++;
      if (par_valid_a !== 1'b0 || q_a.size() != 1) begin
         bad++;
         $display("[TB] FAIL rx_a5 pulse: par_valid=%b pulses=%0d expected 0/1", par_valid_a, q_a.size());
      end
      rx_drive(1, 12'h3F0);
      rx_wait(1, lat);
      check_rx("rx_3f0", 1, lat, 10'h3F0);
      rx_drive(1, 12'hFF0);
      rx_wait(1, lat);
      check_rx("rx_pad", 1, lat, 10'h3F0);
      total++;
      if (par_out_a !== 8'hA5) begin
         bad++;
         $display("[TB] FAIL rx_hold: par_out_a=%h expected a5", par_out_a);
      end
   endtask

   task automatic test_rx_random();
      int lat;
      for (int i = 0; i < 8; i++) begin
         int inst = i % 2;
         logic [11:0] padded;
         padded = 12'($urandom);
         if (inst == 0) padded[11:8] = 4'h0;
         rx_drive(inst, padded);
         rx_wait(inst, lat);
         check_rx("rx_rand", inst, lat, (inst == 0) ? {2'b00, padded[7:0]} : padded[9:0]);
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      logic [7:0] w1, w2;
      w1 = 8'($urandom);
      w2 = 8'($urandom);
      q_a.delete();
      rx_drive(0, {4'h0, w1});
      rx_drive(0, {4'h0, w2});
      rx_wait(0, lat);
      check_rx("b2b_second", 0, lat, {2'b00, w2});
      repeat (4) @(posedge clk);
      total++;
      if (q_a.size() != 2) begin
         bad++;
         $display("[TB] FAIL b2b_count: pulses=%0d expected 2", q_a.size());
      end else if (q_a[0] !== w1 || q_a[1] !== w2) begin
         bad++;
         $display("[TB] FAIL b2b_words: got %h,%h expected %h,%h", q_a[0], q_a[1], w1, w2);
      end
   endtask

   task automatic test_tx();
      tx_accept(0, 10'h03C);
      tx_observe(0, 10'h03C, 0);
      tx_accept(1, 10'h2A5);
      tx_observe(1, 10'h2A5, 0);
      for (int i = 0; i < 4; i++) begin
         int inst = i % 2;
         logic [9:0] d;
         d = 10'($urandom);
         if (inst == 0) d[9:8] = 2'b00;
         tx_accept(inst, d);
         tx_observe(inst, d, 0);
      end
      total++;
      if (overrun_a !== 1'b0 || overrun_b !== 1'b0) begin
         bad++;
         $display("[TB] FAIL tx_no_overrun: overrun a=%b b=%b expected 0", overrun_a, overrun_b);
      end
   endtask

   task automatic test_overrun();
      tx_accept(0, 10'h03C);
      tx_observe(0, 10'h03C, 3);
      total++;
      if (overrun_a !== 1'b1) begin
         bad++;
         $display("[TB] FAIL overrun_set: overrun=%b expected 1", overrun_a);
      end
      tx_accept(0, 10'h081);
      tx_observe(0, 10'h081, 0);
      total++;
      if (overrun_a !== 1'b1 || overrun_b !== 1'b0) begin
         bad++;
         $display("[TB] FAIL overrun_sticky: a=%b b=%b expected 1/0", overrun_a, overrun_b);
      end
   endtask

   task automatic test_concurrent();
      rx_drive(0, 12'h0C3);
      @(posedge clk); #1;
      ser_in_a = 1'b0;
      @(posedge clk); #1;
      drive_cap(0, 1'b1, 10'h096);
      @(posedge clk); #1;
      drive_cap(0, 1'b0, 10'h0);
      total++;
      if (par_valid_a !== 1'b1 || par_out_a !== 8'hC3 || cap_ready_a !== 1'b0) begin
         bad++;
         $display("[TB] FAIL concurrent: pv=%b par_out=%h ready=%b expected 1/c3/0", par_valid_a, par_out_a, cap_ready_a);
      end
      tx_observe(0, 10'h096, 0);
   endtask

   task automatic test_reset_midframe();
      int lat;
      @(posedge clk); #1;
      ser_in_a = 1'b1;
      repeat (4) begin
         @(posedge clk); #1;
         ser_in_a = 1'($urandom);
      end
      reset = 1'b1;
      ser_in_a = 1'b0;
      #1;
      total++;
      if (par_out_a !== 8'h00 || overrun_a !== 1'b0 || cap_ready_a !== 1'b1) begin
         bad++;
         $display("[TB] FAIL async_reset: par_out=%h ovr=%b ready=%b expected 00/0/1", par_out_a, overrun_a, cap_ready_a);
      end
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      q_a.delete();
      rx_drive(0, 12'h05A);
      rx_wait(0, lat);
      check_rx("rx_after_reset", 0, lat, 10'h05A);
      repeat (4) @(posedge clk);
      total++;
      if (q_a.size() != 1) begin
         bad++;
         $display("[TB] FAIL reset_pulses: pulses=%0d expected 1", q_a.size());
      end
   endtask

   initial begin
      test_reset();
      test_rx_directed();
      test_rx_random();
      test_back_to_back();
      test_tx();
      test_overrun();
      test_concurrent();
      test_reset_midframe();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
